// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the round-robin FIFO write arbiter:
// state encoding and the width of the stall statistics counter.
package fifo_arb_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    localparam int STALL_CNT_W = 16;

    typedef enum logic {
        IDLE = ST_IDLE,
        BUSY = ST_BUSY
    } arb_state_t;

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Producer handshake and FIFO write-port bundle shared by the arbiter and its
// surroundings; slave is the arbiter's view, master the producers'/FIFO's.
interface fifo_write_arbiter_if #(
    parameter int NUM_REQ     = 4,
    parameter int WORD_LENGTH = 8
);

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_last;
    logic [NUM_REQ*WORD_LENGTH-1:0] req_data;
    logic [NUM_REQ-1:0]             req_ready;
    logic                           fifo_full;
    logic                           fifo_write_en;
    logic [WORD_LENGTH-1:0]         fifo_data;

    modport master (
        output req_valid, req_last, req_data, fifo_full,
        input  req_ready, fifo_write_en, fifo_data
    );

    modport slave (
        input  req_valid, req_last, req_data, fifo_full,
        output req_ready, fifo_write_en, fifo_data
    );

endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational rotate-priority search: returns the first set bit of valid
// scanning ptr, ptr+1, ... modulo N.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset back to ptr so the nearest hit is written last.
    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr) + k) % N);
            if (valid[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter locking one FIFO write port to a producer per packet/burst.
// Define FIFO_ARB_STATS_EN to build the saturating stall_cycles counter.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int WORD_LENGTH = 8,
    parameter int BURST_MAX   = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    fifo_write_arbiter_if.slave          bus,
    output logic [$clog2(NUM_REQ)-1:0]   owner,
    output logic                         busy,
    output logic [STALL_CNT_W-1:0]       stall_cycles
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int BEAT_W = $clog2(BURST_MAX + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_MAX - 1);

    arb_state_t        state, state_next;
    logic [IDX_W-1:0]  owner_next;
    logic [IDX_W-1:0]  rr_ptr, rr_ptr_next;
    logic [BEAT_W-1:0] beat_cnt, beat_next;
    logic              pick_found;
    logic [IDX_W-1:0]  pick_index;
    logic              transfer;
    logic              grant_done;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .valid (bus.req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .index (pick_index)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_next;
            owner    <= owner_next;
            rr_ptr   <= rr_ptr_next;
            beat_cnt <= beat_next;
        end
    end

    // A stalled or silent owner keeps the grant; only a completed last/burst word releases it.
    always_comb begin
        state_next        = state;
        owner_next        = owner;
        rr_ptr_next       = rr_ptr;
        beat_next         = beat_cnt;
        bus.req_ready     = '0;
        bus.fifo_write_en = 1'b0;
        bus.fifo_data     = '0;
        transfer          = 1'b0;
        grant_done        = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_next = BUSY;
                    owner_next = pick_index;
                    beat_next  = '0;
                end
            end
            BUSY: begin
                bus.req_ready[owner] = ~bus.fifo_full;
                bus.fifo_data        = bus.req_data[owner*WORD_LENGTH +: WORD_LENGTH];
                transfer             = bus.req_valid[owner] && !bus.fifo_full;
                bus.fifo_write_en    = transfer;
                grant_done           = transfer && (bus.req_last[owner] || beat_cnt == LAST_BEAT);
                if (transfer) begin
                    beat_next = beat_cnt + 1'b1;
                end
                if (grant_done) begin
                    state_next  = IDLE;
                    rr_ptr_next = (owner == LAST_IDX) ? '0 : owner + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == BUSY);

`ifdef FIFO_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (state == BUSY && bus.req_valid[owner] && bus.fifo_full
                     && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end
`else
    assign stall_cycles = '0;
`endif

endmodule
